// File: rtl/slice_index_sequencer.sv
// Operand-index sequencer: walks three source lanes and one destination lane
// through a strided slice, one element per non-stalled cycle.

module slice_index_sequencer_lane #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         adv,
  input  logic [W:0]   base,
  input  logic [W-1:0] stride,
  output logic [W:0]   cur_q
);
  logic [W-1:0] stride_q;
  logic [W:0]   cur_d;

  // The valid bit rides along untouched; only the index part advances and wraps.
  always_comb begin
    cur_d = cur_q;
    if (load)     cur_d = base;
    else if (adv) cur_d = {cur_q[W], cur_q[W-1:0] + stride_q};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_q    <= '0;
      stride_q <= '0;
    end else begin
      cur_q <= cur_d;
      if (load) stride_q <= stride;
    end
  end
endmodule

module slice_index_sequencer #(
  parameter int WIDTH_IDX = 8,
  parameter int WIDTH_LEN = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 I_Req,
  output logic                 O_Ready,
  input  logic                 I_Stall,
  input  logic [WIDTH_IDX:0]   I_Src1_Base,
  input  logic [WIDTH_IDX:0]   I_Src2_Base,
  input  logic [WIDTH_IDX:0]   I_Src3_Base,
  input  logic [WIDTH_IDX:0]   I_Dst_Base,
  input  logic [WIDTH_IDX-1:0] I_Stride_Src,
  input  logic [WIDTH_IDX-1:0] I_Stride_Dst,
  input  logic [WIDTH_LEN-1:0] I_Slice_Len,
  output logic [WIDTH_IDX:0]   O_Idx1,
  output logic [WIDTH_IDX:0]   O_Idx2,
  output logic [WIDTH_IDX:0]   O_Idx3,
  output logic [WIDTH_IDX:0]   O_Dst,
  output logic [WIDTH_LEN-1:0] O_Slice_Len,
  output logic                 O_Last,
  output logic                 O_Busy
);
  localparam int NUM_LANES = 4;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic                 state_q, state_d;
  logic [WIDTH_LEN-1:0] cnt_q, cnt_d;
  logic [WIDTH_LEN-1:0] len_q, len_d;
  logic                 run, issue, last, accept, adv;

  logic [NUM_LANES-1:0][WIDTH_IDX:0]   base_w, cur_w, out_w;
  logic [NUM_LANES-1:0][WIDTH_IDX-1:0] stride_w;

  assign run     = (state_q == ST_RUN);
  assign issue   = run & ~I_Stall;
  assign last    = run & (cnt_q == '0);
  assign O_Ready = ~run | (issue & last);
  assign accept  = I_Req & O_Ready;
  assign adv     = issue & ~last;

  assign base_w   = {I_Dst_Base, I_Src3_Base, I_Src2_Base, I_Src1_Base};
  assign stride_w = {I_Stride_Dst, I_Stride_Src, I_Stride_Src, I_Stride_Src};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    slice_index_sequencer_lane #(.W(WIDTH_IDX)) u_lane (
      .clock  (clock),
      .reset  (reset),
      .load   (accept),
      .adv    (adv),
      .base   (base_w[l]),
      .stride (stride_w[l]),
      .cur_q  (cur_w[l])
    );
    // Lanes keep their last index in IDLE, but never advertise it as valid.
    assign out_w[l] = {cur_w[l][WIDTH_IDX] & run, cur_w[l][WIDTH_IDX-1:0]};
  end

  assign O_Idx1      = out_w[0];
  assign O_Idx2      = out_w[1];
  assign O_Idx3      = out_w[2];
  assign O_Dst       = out_w[3];
  assign O_Slice_Len = run ? len_q : '0;
  assign O_Last      = last;
  assign O_Busy      = run;

  // A last-element issue with a pending request reloads directly: no IDLE bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (accept) begin
      state_d = ST_RUN;
      cnt_d   = I_Slice_Len;
      len_d   = I_Slice_Len;
    end else if (issue & last) begin
      state_d = ST_IDLE;
    end else if (adv) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end
endmodule

// File: tb/tb_slice_index_sequencer.sv
// Bench for slice_index_sequencer: element-number reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.

module tb_slice_index_sequencer;
  logic       clock, reset;
  logic       I_Req, I_Stall, O_Ready, O_Last, O_Busy;
  logic [8:0] I_Src1_Base, I_Src2_Base, I_Src3_Base, I_Dst_Base;
  logic [7:0] I_Stride_Src, I_Stride_Dst, I_Slice_Len, O_Slice_Len;
  logic [8:0] O_Idx1, O_Idx2, O_Idx3, O_Dst;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  slice_index_sequencer #(.WIDTH_IDX(8), .WIDTH_LEN(8)) dut (
    .clock(clock), .reset(reset), .I_Req(I_Req), .O_Ready(O_Ready), .I_Stall(I_Stall),
    .I_Src1_Base(I_Src1_Base), .I_Src2_Base(I_Src2_Base), .I_Src3_Base(I_Src3_Base),
    .I_Dst_Base(I_Dst_Base), .I_Stride_Src(I_Stride_Src), .I_Stride_Dst(I_Stride_Dst),
    .I_Slice_Len(I_Slice_Len), .O_Idx1(O_Idx1), .O_Idx2(O_Idx2), .O_Idx3(O_Idx3),
    .O_Dst(O_Dst), .O_Slice_Len(O_Slice_Len), .O_Last(O_Last), .O_Busy(O_Busy)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the instruction in flight and which element number is on the outputs.
  bit         m_busy;
  int         m_k;
  logic [8:0] m_b [4];
  logic [7:0] m_ss, m_sd, m_len;

  function automatic logic [8:0] exp_lane(input int l);
    logic [7:0] st;
    st = (l == 3) ? m_sd : m_ss;
    return {m_b[l][8], 8'(int'(m_b[l][7:0]) + m_k * int'(st))};
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy <= 0;
      m_k    <= 0;
    end else if ((m_busy && !I_Stall && m_k == int'(m_len)) || (!m_busy && I_Req)) begin
      if (I_Req) begin
        m_busy <= 1;
        m_k    <= 0;
        m_b[0] <= I_Src1_Base;
        m_b[1] <= I_Src2_Base;
        m_b[2] <= I_Src3_Base;
        m_b[3] <= I_Dst_Base;
        m_ss   <= I_Stride_Src;
        m_sd   <= I_Stride_Dst;
        m_len  <= I_Slice_Len;
      end else begin
        m_busy <= 0;
      end
    end else if (m_busy && !I_Stall) begin
      m_k <= m_k + 1;
    end
  end

  logic [3:0][8:0] dut_l;
  assign dut_l = {O_Dst, O_Idx3, O_Idx2, O_Idx1};

  always @(negedge clock) begin
    if (reset && chk_en) begin
      automatic bit m_last  = m_busy && (m_k == int'(m_len));
      automatic bit m_ready = !m_busy || (!I_Stall && m_last);
      chk("m_ready", 32'(O_Ready), 32'(m_ready));
      chk("m_busy",  32'(O_Busy),  32'(m_busy));
      chk("m_last",  32'(O_Last),  32'(m_last));
      chk("m_len",   32'(O_Slice_Len), m_busy ? 32'(m_len) : 32'd0);
      for (int l = 0; l < 4; l++) begin
        if (m_busy) chk($sformatf("m_lane%0d", l), 32'(dut_l[l]), 32'(exp_lane(l)));
        else        chk($sformatf("m_lane%0d_v", l), 32'(dut_l[l][8]), 32'd0);
      end
    end
  end

  // Inputs change just after the active edge; outputs are sampled at the next falling edge.
  task automatic cyc(input logic req, input logic stall);
    @(posedge clock);
    #1;
    I_Req   = req;
    I_Stall = stall;
    @(negedge clock);
  endtask

  task automatic set_ins(input logic [8:0] s1, input logic [8:0] s2, input logic [8:0] s3,
                         input logic [8:0] d, input logic [7:0] ss, input logic [7:0] sd,
                         input logic [7:0] len);
    I_Src1_Base = s1; I_Src2_Base = s2; I_Src3_Base = s3; I_Dst_Base = d;
    I_Stride_Src = ss; I_Stride_Dst = sd; I_Slice_Len = len;
  endtask

  int e3 [6] = '{5, 6, 6, 6, 7, 8};
  int e4 [4] = '{5, 6, 7, 40};
  int e5 [4] = '{254, 255, 0, 1};

  initial begin
    reset = 0; I_Req = 0; I_Stall = 0;
    set_ins(9'h0, 9'h0, 9'h0, 9'h0, 8'd0, 8'd0, 8'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_idx1", 32'(O_Idx1), 32'd0);
    chk("rst_dst", 32'(O_Dst), 32'd0);
    chk("rst_len", 32'(O_Slice_Len), 32'd0);
    chk("rst_busy", 32'(O_Busy), 32'd0);
    chk("rst_last", 32'(O_Last), 32'd0);
    reset = 1;
    chk_en = 1;
    cyc(0, 0);
    chk("idle_ready", 32'(O_Ready), 32'd1);

    // Three-operand slice with an unused third source.
    set_ins({1'b1, 8'd5}, {1'b1, 8'd10}, {1'b0, 8'd30}, {1'b1, 8'd20}, 8'd1, 8'd1, 8'd3);
    cyc(1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0);
      chk("t2_idx1", 32'(O_Idx1), 32'({1'b1, 8'(5 + i)}));
      chk("t2_idx2", 32'(O_Idx2), 32'({1'b1, 8'(10 + i)}));
      chk("t2_idx3v", 32'(O_Idx3[8]), 32'd0);
      chk("t2_dst", 32'(O_Dst), 32'({1'b1, 8'(20 + i)}));
      chk("t2_last", 32'(O_Last), 32'(i == 3));
      chk("t2_len", 32'(O_Slice_Len), 32'd3);
    end
    cyc(0, 0);
    chk("t2_idle", 32'(O_Busy), 32'd0);

    // Stall on the 2nd and 3rd cycles of the instruction.
    cyc(1, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, (i == 1 || i == 2));
      chk("t3_idx1", 32'(O_Idx1), 32'({1'b1, 8'(e3[i])}));
      chk("t3_last", 32'(O_Last), 32'(i == 5));
    end
    cyc(0, 0);
    chk("t3_idle", 32'(O_Busy), 32'd0);

    // Back-to-back: next instruction presented during the last element.
    set_ins({1'b1, 8'd5}, {1'b1, 8'd10}, {1'b0, 8'd30}, {1'b1, 8'd20}, 8'd1, 8'd1, 8'd2);
    cyc(1, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        set_ins({1'b1, 8'd40}, {1'b1, 8'd10}, {1'b0, 8'd30}, {1'b1, 8'd20}, 8'd1, 8'd1, 8'd0);
        cyc(1, 0);
        chk("t4_ready", 32'(O_Ready), 32'd1);
      end else begin
        cyc(0, 0);
      end
      chk("t4_idx1", 32'(O_Idx1), 32'({1'b1, 8'(e4[i])}));
      chk("t4_last", 32'(O_Last), 32'(i >= 2));
      chk("t4_busy", 32'(O_Busy), 32'd1);
    end
    cyc(0, 0);
    chk("t4_idle", 32'(O_Busy), 32'd0);

    // Index wraparound.
    set_ins({1'b1, 8'hFE}, {1'b1, 8'd0}, {1'b1, 8'd0}, {1'b1, 8'd0}, 8'd1, 8'd2, 8'd3);
    cyc(1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0);
      chk("t5_idx1", 32'(O_Idx1), 32'({1'b1, 8'(e5[i])}));
    end

    // Scalar, accepted while stalled in IDLE.
    set_ins({1'b1, 8'd3}, {1'b0, 8'd0}, {1'b0, 8'd0}, {1'b1, 8'd9}, 8'd1, 8'd1, 8'd0);
    cyc(0, 1);
    cyc(1, 1);
    chk("t6_ready_stall", 32'(O_Ready), 32'd1);
    cyc(0, 0);
    chk("t6_idx1", 32'(O_Idx1), 32'h103);
    chk("t6_last", 32'(O_Last), 32'd1);
    cyc(0, 0);
    chk("t6_idle_v", 32'(O_Idx1[8]), 32'd0);
    chk("t6_idle_busy", 32'(O_Busy), 32'd0);

    // Maximum length with scattered stalls and odd strides.
    set_ins({1'b1, 8'h10}, {1'b1, 8'h80}, {1'b1, 8'h00}, {1'b1, 8'h33}, 8'd1, 8'd7, 8'd255);
    cyc(1, 0);
    for (int i = 0; i < 262; i++) cyc(0, (i < 200) && (i % 37 == 5));
    chk("tmax_last", 32'(O_Last), 32'd1);
    chk("tmax_idx1", 32'(O_Idx1), 32'h10F);
    chk("tmax_len", 32'(O_Slice_Len), 32'd255);
    cyc(0, 0);
    chk("tmax_idle", 32'(O_Busy), 32'd0);

    // Reset in the middle of an instruction.
    set_ins({1'b1, 8'd9}, {1'b1, 8'd1}, {1'b1, 8'd2}, {1'b1, 8'd3}, 8'd1, 8'd1, 8'd5);
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 0);
    cyc(0, 0);
    chk("t1_pre_idx1", 32'(O_Idx1), 32'h10B);
    reset = 0;
    #1;
    chk("t1_busy", 32'(O_Busy), 32'd0);
    chk("t1_ready", 32'(O_Ready), 32'd1);
    chk("t1_v", 32'({O_Idx1[8], O_Idx2[8], O_Idx3[8], O_Dst[8]}), 32'd0);
    chk("t1_len", 32'(O_Slice_Len), 32'd0);
    @(posedge clock);
    #1;
    reset = 1;
    cyc(0, 0);
    chk("t1_after_busy", 32'(O_Busy), 32'd0);
    cyc(0, 0);
    chk("t1_after_v", 32'(O_Idx1[8]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
